perf_counter_sequencer: RTL

- Hardware-driven Avalon-MM master that sits directly upstream of the 8-section performance counter's control slave.
- Accelerator logic issues section START/STOP/RESET/SNAPSHOT commands; the block converts them into correctly addressed single-cycle write strobes.
- For SNAPSHOT it reads back a tear-free 64-bit time count and the 32-bit event count.
- Section timing needs no Nios II software involvement.

---
 rtl/perf_seq_pkg.sv | 38 +++
 rtl/perf_counter_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_seq_pkg.sv
// Shared encodings for the performance counter sequencer: command opcodes,
// counter slave address layout and the sequencer FSM state type.
package perf_seq_pkg;

  // Command opcodes presented on cmd_op
  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_RESET = 2'd2;
  localparam logic [1:0] OP_SNAP  = 2'd3;

  // Each section occupies four consecutive words in the counter slave
  localparam int SECTION_STRIDE = 4;

  // Write-side offsets within a section
  localparam logic [1:0] OFS_STOP    = 2'd0;
  localparam logic [1:0] OFS_GO      = 2'd1;
  // Read-side offsets within a section
  localparam logic [1:0] OFS_TIME_LO = 2'd0;
  localparam logic [1:0] OFS_TIME_HI = 2'd1;
  localparam logic [1:0] OFS_EVT     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_RD_HI1 = 3'd2,
    S_RD_LO  = 3'd3,
    S_RD_HI2 = 3'd4,
    S_RD_LO2 = 3'd5,
    S_RD_EVT = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  // Word address of a register inside a section
  function automatic logic [4:0] word_addr(input logic [2:0] section, input logic [1:0] offset);
    return 5'(section) * 5'(SECTION_STRIDE) + 5'(offset);
  endfunction

endpackage

// File: rtl/perf_counter_sequencer.sv
// Avalon-MM master that turns section commands into counter slave writes and
// performs a tear-free 64-bit time read plus event read for SNAPSHOT.
// All bus and response outputs are registered; they are computed from the
// next state so they line up with the state they belong to.
module perf_counter_sequencer
  import perf_seq_pkg::*;
#(
  parameter int NUM_SECTIONS = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_section,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [63:0] snap_time,
  output logic [31:0] snap_events,
  output logic [4:0]  pc_address,
  output logic        pc_write,
  output logic        pc_begintransfer,
  output logic [31:0] pc_writedata,
  input  logic [31:0] pc_readdata
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] next_wait_cnt;
  logic [1:0]       cur_op;
  logic [1:0]       next_op;
  logic [2:0]       cur_sec;
  logic [2:0]       next_sec;
  logic             err_flag;
  logic             next_err_flag;
  logic [31:0]      hi1_word;
  logic [31:0]      next_hi1_word;
  logic [31:0]      lo_word;
  logic [31:0]      next_lo_word;
  logic [31:0]      hi2_word;
  logic [31:0]      next_hi2_word;
  logic [63:0]      next_snap_time;
  logic [31:0]      next_snap_events;
  logic [4:0]       next_address;
  logic             next_write;
  logic [31:0]      next_writedata;
  logic             next_rsp_valid;
  logic             next_rsp_error;
  logic             accept;
  logic             out_of_range;
  logic             last_beat;

  assign cmd_ready    = (state == S_IDLE) & ~reset;
  assign accept       = cmd_valid & cmd_ready;
  // RESET is global and never targets a specific section
  assign out_of_range = (cmd_op != OP_RESET) && (32'(cmd_section) >= 32'(NUM_SECTIONS));
  assign last_beat    = (wait_cnt == CNT_LAST);

  // Next-state, wait counter and capture register logic
  always_comb begin
    next_state       = state;
    next_wait_cnt    = wait_cnt;
    next_op          = cur_op;
    next_sec         = cur_sec;
    next_err_flag    = err_flag;
    next_hi1_word    = hi1_word;
    next_lo_word     = lo_word;
    next_hi2_word    = hi2_word;
    next_snap_time   = snap_time;
    next_snap_events = snap_events;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_op       = cmd_op;
          next_sec      = cmd_section;
          next_wait_cnt = '0;
          if (out_of_range) begin
            next_err_flag = 1'b1;
            next_state    = S_RESP;
          end else if (cmd_op == OP_SNAP) begin
            next_err_flag = 1'b0;
            next_state    = S_RD_HI1;
          end else begin
            next_err_flag = 1'b0;
            next_state    = S_WRITE;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WRITE: begin
        next_state = S_RESP;
      end
      S_RD_HI1: begin
        if (last_beat) begin
          next_hi1_word = pc_readdata;
          next_wait_cnt = '0;
          next_state    = S_RD_LO;
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      S_RD_LO: begin
        if (last_beat) begin
          next_lo_word  = pc_readdata;
          next_wait_cnt = '0;
          next_state    = S_RD_HI2;
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      S_RD_HI2: begin
        if (last_beat) begin
          next_hi2_word = pc_readdata;
          next_wait_cnt = '0;
          // A changed high word means the low word wrapped; re-read it once
          if (pc_readdata == hi1_word) begin
            next_state = S_RD_EVT;
          end else begin
            next_state = S_RD_LO2;
          end
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      S_RD_LO2: begin
        if (last_beat) begin
          next_lo_word  = pc_readdata;
          next_wait_cnt = '0;
          next_state    = S_RD_EVT;
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      S_RD_EVT: begin
        if (last_beat) begin
          next_snap_time   = {hi2_word, lo_word};
          next_snap_events = pc_readdata;
          next_wait_cnt    = '0;
          next_state       = S_RESP;
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        next_err_flag = 1'b0;
        next_state    = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Bus and response values for the state about to be entered
  always_comb begin
    next_address   = 5'd0;
    next_write     = 1'b0;
    next_writedata = 32'd0;
    next_rsp_valid = 1'b0;
    next_rsp_error = 1'b0;
    case (next_state)
      S_WRITE: begin
        next_write = 1'b1;
        case (next_op)
          OP_STOP:  next_address = word_addr(next_sec, OFS_STOP);
          OP_START: next_address = word_addr(next_sec, OFS_GO);
          OP_RESET: begin
            next_address   = 5'd0;
            next_writedata = 32'd1;
          end
          default:  next_address = 5'd0;
        endcase
      end
      S_RD_HI1, S_RD_HI2: next_address = word_addr(next_sec, OFS_TIME_HI);
      S_RD_LO, S_RD_LO2:  next_address = word_addr(next_sec, OFS_TIME_LO);
      S_RD_EVT:           next_address = word_addr(next_sec, OFS_EVT);
      S_RESP: begin
        next_rsp_valid = 1'b1;
        next_rsp_error = next_err_flag;
      end
      default: begin
        next_address = 5'd0;
      end
    endcase
  end

  // State, capture and output registers; reset abandons any command in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      cur_op           <= 2'd0;
      cur_sec          <= 3'd0;
      err_flag         <= 1'b0;
      hi1_word         <= 32'd0;
      lo_word          <= 32'd0;
      hi2_word         <= 32'd0;
      snap_time        <= 64'd0;
      snap_events      <= 32'd0;
      pc_address       <= 5'd0;
      pc_write         <= 1'b0;
      pc_begintransfer <= 1'b0;
      pc_writedata     <= 32'd0;
      rsp_valid        <= 1'b0;
      rsp_error        <= 1'b0;
    end else begin
      state            <= next_state;
      wait_cnt         <= next_wait_cnt;
      cur_op           <= next_op;
      cur_sec          <= next_sec;
      err_flag         <= next_err_flag;
      hi1_word         <= next_hi1_word;
      lo_word          <= next_lo_word;
      hi2_word         <= next_hi2_word;
      snap_time        <= next_snap_time;
      snap_events      <= next_snap_events;
      pc_address       <= next_address;
      pc_write         <= next_write;
      pc_begintransfer <= next_write;
      pc_writedata     <= next_writedata;
      rsp_valid        <= next_rsp_valid;
      rsp_error        <= next_rsp_error;
    end
  end

endmodule
